// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-clock VGA raster generator.
//   Scans h/v counters, presents the requested pixel coordinate to a pattern
//   source and drives RGB, HS, VS, BLANK_N and a frame-start pulse to the DAC.
//   All DAC outputs are mutually aligned, PIX_DLY+1 clocks after the counter
//   state that produced them.
// Ports:
//   iVGA_CLK, iRST           pixel clock, synchronous active-high reset
//   oVGA_X, oVGA_Y, oRequest requested pixel coordinate / active flag (stage 0)
//   iRed, iGreen, iBlue      pattern data, valid PIX_DLY clocks after request
//   oVGA_R, oVGA_G, oVGA_B   registered colour to DAC
//   oVGA_HS, oVGA_VS         syncs, active level SYNC_POL
//   oVGA_BLANK_N             low during blanking
//   oFrameStart              one-clock pulse with pixel (0,0) at the DAC
// Build option:
//   VGA_TIMING_BORDER_EN     force 10'h3FF on the outermost active pixels
module vga_timing_ctrl #(
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_DLY  = 1,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        iVGA_CLK,
    input  logic        iRST,
    output logic [9:0]  oVGA_X,
    output logic [9:0]  oVGA_Y,
    output logic        oRequest,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    output logic [9:0]  oVGA_R,
    output logic [9:0]  oVGA_G,
    output logic [9:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N,
    output logic        oFrameStart
);

    localparam int unsigned CW        = 10;
    localparam int unsigned H_TOTAL   = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_S  = H_ACT + H_FP;
    localparam int unsigned H_SYNC_E  = H_ACT + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_S  = V_ACT + V_FP;
    localparam int unsigned V_SYNC_E  = V_ACT + V_FP + V_SYNC;

    // Flag vector bit positions carried through the alignment delay line
    localparam int unsigned F_HS  = 0;
    localparam int unsigned F_VS  = 1;
    localparam int unsigned F_ACT = 2;
    localparam int unsigned F_FS  = 3;
`ifdef VGA_TIMING_BORDER_EN
    localparam int unsigned F_BRD = 4;
    localparam int unsigned FW    = 5;
`else
    localparam int unsigned FW    = 4;
`endif

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          w_act;
    logic [FW-1:0] w_flags;
    logic [FW-1:0] w_dly;
    logic [CW-1:0] w_r;
    logic [CW-1:0] w_g;
    logic [CW-1:0] w_b;

    // Raster counters; v advances on the h wrap
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == CW'(H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            if (r_v_cnt == CW'(V_TOTAL - 1)) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + CW'(1);
            end
        end else begin
            r_h_cnt <= r_h_cnt + CW'(1);
        end
    end

    // Stage-0 decode: request side and flags entering the delay line
    assign w_act    = (r_h_cnt < CW'(H_ACT)) && (r_v_cnt < CW'(V_ACT));
    assign oRequest = w_act;
    assign oVGA_X   = w_act ? r_h_cnt : '0;
    assign oVGA_Y   = w_act ? r_v_cnt : '0;

    always_comb begin
        w_flags        = '0;
        w_flags[F_HS]  = (r_h_cnt >= CW'(H_SYNC_S)) && (r_h_cnt < CW'(H_SYNC_E));
        w_flags[F_VS]  = (r_v_cnt >= CW'(V_SYNC_S)) && (r_v_cnt < CW'(V_SYNC_E));
        w_flags[F_ACT] = w_act;
        w_flags[F_FS]  = (r_h_cnt == '0) && (r_v_cnt == '0);
`ifdef VGA_TIMING_BORDER_EN
        w_flags[F_BRD] = w_act && ((r_h_cnt == '0) || (r_h_cnt == CW'(H_ACT - 1)) ||
                                   (r_v_cnt == '0) || (r_v_cnt == CW'(V_ACT - 1)));
`endif
    end

    // PIX_DLY stages here plus the output register give PIX_DLY+1 total
    generate
        if (PIX_DLY == 0) begin : g_no_dly
            assign w_dly = w_flags;
        end else begin : g_dly
            logic [FW-1:0] r_pipe [PIX_DLY];
            always_ff @(posedge iVGA_CLK) begin
                if (iRST) begin
                    for (int unsigned i = 0; i < PIX_DLY; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_flags;
                    for (int unsigned i = 1; i < PIX_DLY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end
            assign w_dly = r_pipe[PIX_DLY-1];
        end
    endgenerate

    // Colour select: pattern data arriving with the delayed flag belongs to it
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_dly[F_ACT]) begin
            w_r = iRed;
            w_g = iGreen;
            w_b = iBlue;
`ifdef VGA_TIMING_BORDER_EN
            if (w_dly[F_BRD]) begin
                w_r = 10'h3FF;
                w_g = 10'h3FF;
                w_b = 10'h3FF;
            end
`endif
        end
    end

    // DAC output register
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= ~SYNC_POL;
            oVGA_VS      <= ~SYNC_POL;
            oVGA_BLANK_N <= 1'b0;
            oFrameStart  <= 1'b0;
        end else begin
            oVGA_R       <= w_r;
            oVGA_G       <= w_g;
            oVGA_B       <= w_b;
            oVGA_HS      <= w_dly[F_HS] ? SYNC_POL : ~SYNC_POL;
            oVGA_VS      <= w_dly[F_VS] ? SYNC_POL : ~SYNC_POL;
            oVGA_BLANK_N <= w_dly[F_ACT];
            oFrameStart  <= w_dly[F_FS];
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three instances (default timing, default with
// PIX_DLY=3, and a tiny raster for whole-frame and reset scenarios).
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fs;
    } dac_t;

    typedef struct packed {
        logic       rq;
        logic [9:0] x;
        logic [9:0] y;
    } req_t;

    // Tiny raster: 25 clocks per line, 13 lines per frame, 325 clocks per frame
    localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = 25, S_VT = 13, S_DLY = 2;
    localparam int PX [5] = '{0, 15, 3, 3, 3};
    localparam int PY [5] = '{3, 3, 0, 5, 3};
    localparam bit PB [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int mh, mv;
    dac_t exp_q [$];

    // Default instance
    logic       rst_d;
    logic [9:0] d_ir, d_ig, d_ib, d_x, d_y, d_r, d_g, d_b;
    logic       d_rq, d_hs, d_vs, d_bn, d_fs;
    // PIX_DLY=3 instance
    logic       rst_p;
    logic [9:0] p_ir, p_ig, p_ib, p_x, p_y, p_r, p_g, p_b;
    logic       p_rq, p_hs, p_vs, p_bn, p_fs;
    // Tiny instance, active-high syncs
    logic       rst_s;
    logic [9:0] s_ir, s_ig, s_ib, s_x, s_y, s_r, s_g, s_b;
    logic       s_rq, s_hs, s_vs, s_bn, s_fs;

    dac_t got_d, got_p, got_s;
    req_t rq_d, rq_p, rq_s;
    assign got_d = {d_r, d_g, d_b, d_hs, d_vs, d_bn, d_fs};
    assign got_p = {p_r, p_g, p_b, p_hs, p_vs, p_bn, p_fs};
    assign got_s = {s_r, s_g, s_b, s_hs, s_vs, s_bn, s_fs};
    assign rq_d  = {d_rq, d_x, d_y};
    assign rq_p  = {p_rq, p_x, p_y};
    assign rq_s  = {s_rq, s_x, s_y};

    vga_timing_ctrl u_def (
        .iVGA_CLK(clk), .iRST(rst_d), .oVGA_X(d_x), .oVGA_Y(d_y), .oRequest(d_rq),
        .iRed(d_ir), .iGreen(d_ig), .iBlue(d_ib), .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b),
        .oVGA_HS(d_hs), .oVGA_VS(d_vs), .oVGA_BLANK_N(d_bn), .oFrameStart(d_fs)
    );

    vga_timing_ctrl #(.PIX_DLY(3)) u_p3 (
        .iVGA_CLK(clk), .iRST(rst_p), .oVGA_X(p_x), .oVGA_Y(p_y), .oRequest(p_rq),
        .iRed(p_ir), .iGreen(p_ig), .iBlue(p_ib), .oVGA_R(p_r), .oVGA_G(p_g), .oVGA_B(p_b),
        .oVGA_HS(p_hs), .oVGA_VS(p_vs), .oVGA_BLANK_N(p_bn), .oFrameStart(p_fs)
    );

    vga_timing_ctrl #(
        .H_ACT(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACT(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .PIX_DLY(S_DLY), .SYNC_POL(1'b1)
    ) u_sml (
        .iVGA_CLK(clk), .iRST(rst_s), .oVGA_X(s_x), .oVGA_Y(s_y), .oRequest(s_rq),
        .iRed(s_ir), .iGreen(s_ig), .iBlue(s_ib), .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
        .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_BLANK_N(s_bn), .oFrameStart(s_fs)
    );

    // Reference DAC value for raster position (h,v) given the pattern returned for it
    function automatic dac_t f_dac(input int h, input int v, input int ha, input int hf,
                                   input int hsw, input int va, input int vf, input int vsw,
                                   input logic pol, input logic [9:0] pr, input logic [9:0] pg,
                                   input logic [9:0] pb);
        dac_t d;
        logic act, brd;
        act = (h < ha) && (v < va);
        brd = 1'b0;
`ifdef VGA_TIMING_BORDER_EN
        brd = act && (h == 0 || h == ha - 1 || v == 0 || v == va - 1);
`endif
        d.r  = act ? (brd ? 10'h3FF : pr) : 10'd0;
        d.g  = act ? (brd ? 10'h3FF : pg) : 10'd0;
        d.b  = act ? (brd ? 10'h3FF : pb) : 10'd0;
        d.hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
        d.vs = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
        d.bn = act;
        d.fs = (h == 0) && (v == 0);
        return d;
    endfunction

    function automatic dac_t f_rst(input logic pol);
        dac_t d;
        d    = '0;
        d.hs = ~pol;
        d.vs = ~pol;
        return d;
    endfunction

    function automatic req_t f_req(input int h, input int v, input int ha, input int va);
        req_t q;
        q.rq = (h < ha) && (v < va);
        q.x  = q.rq ? 10'(h) : 10'd0;
        q.y  = q.rq ? 10'(v) : 10'd0;
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int ht, input int vt);
        mh = mh + 1;
        if (mh == ht) begin
            mh = 0;
            mv = (mv + 1 == vt) ? 0 : mv + 1;
        end
    endtask

    // Queue holds what the DAC shows for the next LAT cycles; starts as reset values
    task automatic sb_init(input int lat, input logic pol);
        exp_q.delete();
        repeat (lat) exp_q.push_back(f_rst(pol));
        mh = 0;
        mv = 0;
    endtask

    task automatic test_reset();
        rst_d = 1'b1; rst_p = 1'b1; rst_s = 1'b1;
        repeat (3) tick();
        n_chk++; if (rq_d !== f_req(0, 0, 640, 480)) begin n_err++; $display("FAIL reset_req_def got=%h exp=%h", rq_d, f_req(0, 0, 640, 480)); end
        n_chk++; if (got_d !== f_rst(1'b0)) begin n_err++; $display("FAIL reset_dac_def got=%h exp=%h", got_d, f_rst(1'b0)); end
        n_chk++; if (rq_p !== f_req(0, 0, 640, 480)) begin n_err++; $display("FAIL reset_req_p3 got=%h exp=%h", rq_p, f_req(0, 0, 640, 480)); end
        n_chk++; if (got_p !== f_rst(1'b0)) begin n_err++; $display("FAIL reset_dac_p3 got=%h exp=%h", got_p, f_rst(1'b0)); end
        n_chk++; if (rq_s !== f_req(0, 0, S_HA, S_VA)) begin n_err++; $display("FAIL reset_req_sml got=%h exp=%h", rq_s, f_req(0, 0, S_HA, S_VA)); end
        n_chk++; if (got_s !== f_rst(1'b1)) begin n_err++; $display("FAIL reset_dac_sml got=%h exp=%h", got_s, f_rst(1'b1)); end
    endtask

    task automatic test_line_timing();
        dac_t e;
        int rise1, rise2, fall1, hs_start, hs_len;
        logic prev_bn;
        rise1 = -1; rise2 = -1; fall1 = -1; hs_start = -1; hs_len = 0; prev_bn = 1'b0;
        d_ir = 10'd0; d_ig = 10'd512; d_ib = 10'd0;
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        sb_init(2, 1'b0);
        for (int c = 0; c < 1700; c++) begin
            if (c > 0) begin tick(); adv(800, 525); end
            n_chk++; if (rq_d !== f_req(mh, mv, 640, 480)) begin n_err++; $display("FAIL line_req c=%0d got=%h exp=%h", c, rq_d, f_req(mh, mv, 640, 480)); end
            exp_q.push_back(f_dac(mh, mv, 640, 16, 96, 480, 10, 2, 1'b0, 10'd0, 10'd512, 10'd0));
            e = exp_q.pop_front();
            n_chk++; if (got_d !== e) begin n_err++; $display("FAIL line_dac c=%0d got=%h exp=%h", c, got_d, e); end
            if (got_d.bn && !prev_bn) begin
                if (rise1 < 0) rise1 = c; else if (rise2 < 0) rise2 = c;
            end
            if (!got_d.bn && prev_bn && fall1 < 0) fall1 = c;
            if (!got_d.hs && c < 800) begin
                if (hs_start < 0) hs_start = c;
                hs_len++;
            end
            prev_bn = got_d.bn;
        end
        n_chk++; if (rise1 != 2) begin n_err++; $display("FAIL blank_rise got=%0d exp=2", rise1); end
        n_chk++; if (fall1 != 642) begin n_err++; $display("FAIL blank_fall got=%0d exp=642", fall1); end
        n_chk++; if (hs_start != 658) begin n_err++; $display("FAIL hs_start got=%0d exp=658", hs_start); end
        n_chk++; if (hs_len != 96) begin n_err++; $display("FAIL hs_len got=%0d exp=96", hs_len); end
        n_chk++; if (rise2 - rise1 != 800) begin n_err++; $display("FAIL line_period got=%0d exp=800", rise2 - rise1); end
    endtask

    task automatic test_green();
        int act_cnt;
        logic ok;
        act_cnt = 0;
        d_ir = 10'd0; d_ig = 10'd512; d_ib = 10'd0;
        rst_d = 1'b1; tick(); rst_d = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (c > 0) tick();
            if (d_bn) act_cnt++;
            ok = d_bn ? (d_g == 10'd512 && d_r == 10'd0 && d_b == 10'd0)
                      : (d_g == 10'd0 && d_r == 10'd0 && d_b == 10'd0);
`ifdef VGA_TIMING_BORDER_EN
            if (d_bn && d_r == 10'h3FF && d_g == 10'h3FF && d_b == 10'h3FF) ok = 1'b1;
`endif
            n_chk++; if (!ok) begin n_err++; $display("FAIL green c=%0d got r=%0d g=%0d b=%0d bn=%b exp g=%0d r=b=0", c, d_r, d_g, d_b, d_bn, d_bn ? 512 : 0); end
        end
        n_chk++; if (act_cnt != 1678) begin n_err++; $display("FAIL green_active_cnt got=%0d exp=1678", act_cnt); end
    endtask

    task automatic test_pixel_order();
        dac_t e;
        logic [9:0] xq [$];
        int act_cnt, col;
        act_cnt = 0; col = 0;
        p_ir = 10'd0; p_ig = 10'd0; p_ib = 10'd0;
        rst_p = 1'b1; tick(); rst_p = 1'b0;
        sb_init(4, 1'b0);
        for (int c = 0; c < 2400; c++) begin
            if (c > 0) begin tick(); adv(800, 525); end
            n_chk++; if (rq_p !== f_req(mh, mv, 640, 480)) begin n_err++; $display("FAIL p3_req c=%0d got=%h exp=%h", c, rq_p, f_req(mh, mv, 640, 480)); end
            exp_q.push_back(f_dac(mh, mv, 640, 16, 96, 480, 10, 2, 1'b0, 10'(mh), 10'd0, 10'd0));
            e = exp_q.pop_front();
            n_chk++; if (got_p !== e) begin n_err++; $display("FAIL p3_dac c=%0d got=%h exp=%h", c, got_p, e); end
            if (p_bn) begin
                act_cnt++;
`ifndef VGA_TIMING_BORDER_EN
                n_chk++; if (p_r !== 10'(col)) begin n_err++; $display("FAIL p3_col c=%0d got=%0d exp=%0d", c, p_r, col); end
`endif
                col++;
            end else begin
                col = 0;
            end
            // Pattern source: return the X requested three clocks earlier
            xq.push_back(p_x);
            if (xq.size() > 3) p_ir = xq.pop_front();
        end
        n_chk++; if (act_cnt != 1920) begin n_err++; $display("FAIL p3_active_cnt got=%0d exp=1920", act_cnt); end
    endtask

    task automatic test_frame();
        dac_t e;
        int fs_cnt, fs1, fs2, vs_start, vs_cnt, bn_cnt;
        fs_cnt = 0; fs1 = -1; fs2 = -1; vs_start = -1; vs_cnt = 0; bn_cnt = 0;
        s_ir = 10'h155; s_ig = 10'h2AA; s_ib = 10'h0F0;
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        sb_init(S_DLY + 1, 1'b1);
        for (int c = 0; c < 640; c++) begin
            if (c > 0) begin tick(); adv(S_HT, S_VT); end
            n_chk++; if (rq_s !== f_req(mh, mv, S_HA, S_VA)) begin n_err++; $display("FAIL frame_req c=%0d got=%h exp=%h", c, rq_s, f_req(mh, mv, S_HA, S_VA)); end
            exp_q.push_back(f_dac(mh, mv, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b1, 10'h155, 10'h2AA, 10'h0F0));
            e = exp_q.pop_front();
            n_chk++; if (got_s !== e) begin n_err++; $display("FAIL frame_dac c=%0d got=%h exp=%h", c, got_s, e); end
            if (s_fs) begin
                fs_cnt++;
                if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
            end
            if (c >= 3 && c < 328) begin
                if (s_bn) bn_cnt++;
                if (s_vs) begin
                    if (vs_start < 0) vs_start = c;
                    vs_cnt++;
                end
            end
        end
        n_chk++; if (fs_cnt != 2) begin n_err++; $display("FAIL fs_count got=%0d exp=2", fs_cnt); end
        n_chk++; if (fs1 != 3) begin n_err++; $display("FAIL fs_first got=%0d exp=3", fs1); end
        n_chk++; if (fs2 - fs1 != 325) begin n_err++; $display("FAIL frame_period got=%0d exp=325", fs2 - fs1); end
        n_chk++; if (bn_cnt != 96) begin n_err++; $display("FAIL frame_active got=%0d exp=96", bn_cnt); end
        n_chk++; if (vs_start != 203) begin n_err++; $display("FAIL vs_start got=%0d exp=203", vs_start); end
        n_chk++; if (vs_cnt != 50) begin n_err++; $display("FAIL vs_len got=%0d exp=50", vs_cnt); end
    endtask

    task automatic test_mid_reset();
        dac_t e;
        int hs_run, pulses;
        logic post, done;
        hs_run = 0; pulses = 0; post = 1'b0; done = 1'b0;
        s_ir = 10'h155; s_ig = 10'h2AA; s_ib = 10'h0F0;
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        sb_init(S_DLY + 1, 1'b1);
        for (int c = 0; c < 800; c++) begin
            if (c > 0) begin
                tick();
                if (rst_s) begin
                    rst_s = 1'b0;
                    sb_init(S_DLY + 1, 1'b1);
                    post = 1'b1;
                end else begin
                    adv(S_HT, S_VT);
                end
            end
            if (post) begin
                n_chk++; if (rq_s !== req_t'({1'b1, 10'd0, 10'd0})) begin n_err++; $display("FAIL mid_reset_req got=%h exp=%h", rq_s, {1'b1, 10'd0, 10'd0}); end
                post = 1'b0;
            end
            n_chk++; if (rq_s !== f_req(mh, mv, S_HA, S_VA)) begin n_err++; $display("FAIL mid_req c=%0d got=%h exp=%h", c, rq_s, f_req(mh, mv, S_HA, S_VA)); end
            exp_q.push_back(f_dac(mh, mv, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, 1'b1, 10'h155, 10'h2AA, 10'h0F0));
            e = exp_q.pop_front();
            n_chk++; if (got_s !== e) begin n_err++; $display("FAIL mid_dac c=%0d got=%h exp=%h", c, got_s, e); end
            if (s_hs) begin
                hs_run++;
            end else if (hs_run > 0) begin
                pulses++;
                n_chk++; if (hs_run != S_HS) begin n_err++; $display("FAIL mid_hs_width c=%0d got=%0d exp=%0d", c, hs_run, S_HS); end
                hs_run = 0;
            end
            if (!done && mh == 10 && mv == 3) begin
                rst_s = 1'b1;
                done  = 1'b1;
            end
        end
        n_chk++; if (pulses < 20) begin n_err++; $display("FAIL mid_hs_pulses got=%0d exp>=20", pulses); end
    endtask

    task automatic test_border();
        logic [29:0] exp_rgb;
        s_ir = 10'd0; s_ig = 10'd0; s_ib = 10'd0;
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        for (int c = 0; c < 160; c++) begin
            if (c > 0) tick();
            for (int k = 0; k < 5; k++) begin
                if (c == S_DLY + 1 + PY[k] * S_HT + PX[k]) begin
                    exp_rgb = 30'd0;
`ifdef VGA_TIMING_BORDER_EN
                    if (PB[k]) exp_rgb = {3{10'h3FF}};
`endif
                    n_chk++; if ({s_r, s_g, s_b} !== exp_rgb || s_bn !== 1'b1) begin n_err++; $display("FAIL border x=%0d y=%0d got=%h bn=%b exp=%h bn=1", PX[k], PY[k], {s_r, s_g, s_b}, s_bn, exp_rgb); end
                end
            end
        end
    endtask

    initial begin
        d_ir = '0; d_ig = '0; d_ib = '0;
        p_ir = '0; p_ig = '0; p_ib = '0;
        s_ir = '0; s_ig = '0; s_ib = '0;
        rst_d = 1'b1; rst_p = 1'b1; rst_s = 1'b1;
        test_reset();
        test_line_timing();
        test_green();
        test_pixel_order();
        test_frame();
        test_mid_reset();
        test_border();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
